// File: rtl/fifo_word_assembler_pkg.sv
// fifo_assembler_pkg: state type and counter-width helper shared by the word assembler files
package fifo_assembler_pkg;
  typedef enum logic {COLLECT, HOLD} asm_state_t;
  function automatic int CNT_W(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/fifo_word_assembler_if.sv
// fifo_word_assembler_if: FIFO read port plus wide valid/ready output stream
// master (assembler): in fifo_empty, fifo_rdata, out_ready; out fifo_re, out_data, out_count, out_valid
// slave (FIFO + downstream side): the mirror image
interface fifo_word_assembler_if
  import fifo_assembler_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LANES = 4
);
  logic                        fifo_empty;
  logic [WIDTH-1:0]            fifo_rdata;
  logic                        fifo_re;
  logic [WIDTH*LANES-1:0]      out_data;
  logic [CNT_W(LANES)-1:0]     out_count;
  logic                        out_valid;
  logic                        out_ready;
  modport master (
    input  fifo_empty, fifo_rdata, out_ready,
    output fifo_re, out_data, out_count, out_valid
  );
  modport slave (
    output fifo_empty, fifo_rdata, out_ready,
    input  fifo_re, out_data, out_count, out_valid
  );
endinterface

// File: rtl/fifo_word_assembler_idle_timer.sv
// idle_timer: counts enabled cycles, clears when disabled or on terminal count
// ports: clk, rst_n (async active-low), i_en (count this cycle), o_tc (this enabled cycle is the TIMEOUT-th)
module idle_timer
  import fifo_assembler_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_tc
);
  localparam int CW = CNT_W(TIMEOUT);
  logic [CW-1:0] r_cnt;
  assign o_tc = i_en && (r_cnt == CW'(TIMEOUT - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else r_cnt <= (i_en && !o_tc) ? r_cnt + 1'b1 : '0;
endmodule

// File: rtl/fifo_word_assembler.sv
// fifo_word_assembler: pops LANES narrow FIFO words and offers them as one wide valid/ready word
// ports: clk, rst_n (async active-low), bus (fifo_word_assembler_if.master: FIFO read port + output stream)
// FIFO_ASSEMBLER_TIMEOUT_EN: when defined, a partial word is flushed after TIMEOUT idle cycles
module fifo_word_assembler
  import fifo_assembler_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int LANES   = 4,
  parameter int TIMEOUT = 15
) (
  input logic                  clk,
  input logic                  rst_n,
  fifo_word_assembler_if.master bus
);
  localparam int IW = $clog2(LANES);
  localparam int CW = CNT_W(LANES);
  if (LANES < 2 || TIMEOUT < 1) begin : g_bad_param
    $error("fifo_word_assembler: LANES must be >= 2 and TIMEOUT >= 1");
  end
  asm_state_t             r_state, w_state;
  logic [IW-1:0]          r_idx, w_idx;
  logic [WIDTH*LANES-1:0] r_data, w_data;
  logic [CW-1:0]          r_count, w_count;
  logic                   w_pop, w_flush;
  // gated by rst_n so no pop is requested while the block is held in reset
  assign w_pop         = rst_n && (r_state == COLLECT) && !bus.fifo_empty;
  assign bus.fifo_re   = w_pop;
  assign bus.out_data  = r_data;
  assign bus.out_count = r_count;
  assign bus.out_valid = (r_state == HOLD);
`ifdef FIFO_ASSEMBLER_TIMEOUT_EN
  idle_timer #(.TIMEOUT(TIMEOUT)) u_idle_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .i_en ((r_state == COLLECT) && (r_idx != '0) && bus.fifo_empty),
    .o_tc (w_flush)
  );
`else
  assign w_flush = 1'b0;
`endif
  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_data  = r_data;
    w_count = r_count;
    if (r_state == HOLD) begin
      if (bus.out_ready) begin
        w_state = COLLECT;
        w_idx   = '0;
        w_data  = '0;
        w_count = '0;
      end
    end else if (w_pop) begin
      w_data[r_idx*WIDTH +: WIDTH] = bus.fifo_rdata;
      w_idx = r_idx + 1'b1;
      if (r_idx == IW'(LANES - 1)) begin
        w_state = HOLD;
        w_idx   = '0;
        w_count = CW'(LANES);
      end
    end else if (w_flush) begin
      w_state = HOLD;
      w_idx   = '0;
      w_count = CW'(r_idx);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= COLLECT;
      r_idx   <= '0;
      r_data  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state;
      r_idx   <= w_idx;
      r_data  <= w_data;
      r_count <= w_count;
    end
endmodule

// File: tb/tb_fifo_word_assembler.sv
// tb_fifo_word_assembler: directed stimulus with a queue scoreboard checked by a negedge monitor
module tb_fifo_word_assembler;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  fifo_word_assembler_if #(.WIDTH(4), .LANES(4)) bus ();
  fifo_word_assembler #(.WIDTH(4), .LANES(4), .TIMEOUT(15)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );
  logic [3:0]  mem [256];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        gate = 0;
  logic [18:0] exp_q [$];
  int          total = 0;
  int          bad = 0;
  assign bus.fifo_empty = (rd_ptr == wr_ptr) || gate;
  assign bus.fifo_rdata = mem[rd_ptr[7:0]];
  always @(posedge clk) if (bus.fifo_re) rd_ptr <= rd_ptr + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask
  task automatic push(input logic [3:0] w);
    mem[wr_ptr[7:0]] = w;
    wr_ptr++;
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step(1);
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask
  task automatic wait_valid(input string name, input int req);
    int n = 0;
    while (!bus.out_valid && n < 100) begin
      step(1);
      n++;
    end
    chk(name, n, req);
  endtask
  logic        p_valid = 0;
  logic        p_ready = 0;
  logic [18:0] p_word = '0;
  always @(negedge clk) begin
    if (!rst_n) p_valid = 0;
    else begin
      if (p_valid && !p_ready) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_stable", {bus.out_count, bus.out_data}, p_word);
      end
      if (bus.fifo_empty) chk("no_pop_empty", bus.fifo_re, 0);
      if (bus.out_valid && bus.out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_word: got %0h, want none", {bus.out_count, bus.out_data});
        end else begin
          logic [18:0] e;
          e = exp_q.pop_front();
          if ({bus.out_count, bus.out_data} !== e) begin
            bad++;
            $display("FAIL word: got %0h, want %0h", {bus.out_count, bus.out_data}, e);
          end
        end
      end
      p_valid = bus.out_valid;
      p_ready = bus.out_ready;
      p_word  = {bus.out_count, bus.out_data};
    end
  end
  initial begin
    int start;
    logic seen;
    bus.out_ready = 1;
    step(2);
    foreach (mem[i]) mem[i] = 4'h0;
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    exp_q.push_back({3'd4, 16'h4321});
    step(1);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_count", bus.out_count, 0);
    chk("rst_re", bus.fifo_re, 0);
    start = rd_ptr;
    rst_n = 1;
    drain("full_word");
    chk("full_pops", rd_ptr - start, 4);
    chk("full_one_cycle", bus.out_valid, 0);
    bus.out_ready = 0;
    push(4'h5); push(4'h6); push(4'h7); push(4'h8);
    push(4'h9); push(4'ha); push(4'hb); push(4'hc);
    exp_q.push_back({3'd4, 16'h8765});
    exp_q.push_back({3'd4, 16'hcba9});
    wait_valid("bp_valid_rise", 4);
    repeat (10) begin
      chk("bp_re", bus.fifo_re, 0);
      step(1);
    end
    chk("bp_count", bus.out_count, 4);
    bus.out_ready = 1;
    step(1);
    chk("bp_release", bus.out_valid, 0);
    drain("bp_words");
    start = rd_ptr;
    for (int i = 1; i <= 8; i++) push(4'(i));
    exp_q.push_back({3'd4, 16'h4321});
    exp_q.push_back({3'd4, 16'h8765});
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) begin
      gate = ~gate;
      step(1);
    end
    gate = 0;
    chk("sparse_done", exp_q.size(), 0);
    chk("sparse_pops", rd_ptr - start, 8);
`ifdef FIFO_ASSEMBLER_TIMEOUT_EN
    bus.out_ready = 0;
    push(4'ha); push(4'hb);
    exp_q.push_back({3'd2, 16'h00ba});
    wait_valid("flush_delay", 17);
    chk("flush_count", bus.out_count, 2);
    bus.out_ready = 1;
    drain("flush_word");
`else
    bus.out_ready = 1;
    push(4'ha); push(4'hb);
    seen = 0;
    repeat (100) begin
      step(1);
      if (bus.out_valid) seen = 1;
    end
    chk("no_flush", seen, 0);
    exp_q.push_back({3'd4, 16'hdcba});
    push(4'hc); push(4'hd);
    drain("no_flush_full");
`endif
    bus.out_ready = 1;
    push(4'h1); push(4'h2); push(4'h3);
    step(5);
    rst_n = 0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_data", bus.out_data, 0);
    chk("mid_rst_count", bus.out_count, 0);
    push(4'he); push(4'hf); push(4'h1); push(4'h2);
    step(2);
    chk("mid_rst_re", bus.fifo_re, 0);
    exp_q.push_back({3'd4, 16'h21fe});
    rst_n = 1;
    drain("reset_word");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
